// File: rtl/rom_search_pkg.sv
// Shared definitions for the inverse-ROM-lookup block: default geometry
// and the controller state encoding.
package rom_search_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/rom_search_rom.sv
// Combinational lookup table that sits beside rom_search. Its contents
// are the reference word set used at system level; any address outside
// the first eight reads as zero.
module ROM
  import rom_search_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [ADDR_W-1:0] i_adr,
  output logic [DATA_W-1:0] o_data
);

  // Asynchronous read: the word follows the address within the same cycle.
  always_comb begin
    o_data = '0;
    case (int'(i_adr))
      0:       o_data = DATA_W'(0);
      1:       o_data = DATA_W'(13);
      2:       o_data = DATA_W'(10);
      3:       o_data = DATA_W'(8);
      4:       o_data = DATA_W'(4);
      5:       o_data = DATA_W'(11);
      6:       o_data = DATA_W'(2);
      7:       o_data = DATA_W'(1);
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/rom_search.sv
// Inverse ROM lookup: walks an external combinational ROM from address 0
// upward, one word per cycle, and reports the lowest address holding the
// requested key. Every output comes straight from a flop.
module rom_search
  import rom_search_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] key,
  output logic [ADDR_W-1:0] ROM_adr,
  input  logic [DATA_W-1:0] ROM_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] match_adr
);

  state_t            r_state;
  logic [DATA_W-1:0] r_key;
  logic              w_hit;
  logic              w_last;

  // The only combinational path: current ROM word against the latched key.
  always_comb begin
    w_hit  = (ROM_data == r_key);
    w_last = (ROM_adr == {ADDR_W{1'b1}});
  end

  // Controller and all result registers; reset wins over any request.
  // NOTE: every flop here is assigned with <= so all branches see the
  // pre-edge values, exactly as the hardware does.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_key     <= '0;
      ROM_adr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      match_adr <= '0;
    end else begin
      // done is a pulse: it drops on the edge after it rises.
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          ROM_adr <= '0;
          if (start) begin
            r_key     <= key;
            busy      <= 1'b1;
            found     <= 1'b0;
            match_adr <= '0;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          if (w_hit) begin
            found     <= 1'b1;
            match_adr <= ROM_adr;
            done      <= 1'b1;
            busy      <= 1'b0;
            ROM_adr   <= '0;
            r_state   <= IDLE;
          end else if (w_last) begin
            // Table exhausted without a hit; stop rather than wrap.
            found     <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            ROM_adr   <= '0;
            r_state   <= IDLE;
          end else begin
            ROM_adr <= ROM_adr + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          ROM_adr <= '0;
        end
      endcase
    end
  end

endmodule
